// File: rtl/td4_fetch.sv
// ---------------------------------------------------------------------------
// td4_fetch : instruction fetch / sequencer for the 4-bit CPU.
//
// Holds a loadable program memory and the program counter. It reads one
// instruction per FETCH cycle and presents it to decode/execute over a
// valid/ready handshake. On acceptance it applies the jump returned by
// execute. A jump to itself on an 0xF op whose immediate names its own
// address is treated as a halt.
//
// Ports
//   in_clk        clock, rising edge
//   in_rst_n      synchronous reset, active-low (memory is not cleared)
//   in_load_en    program memory write strobe (honoured only while idle)
//   in_load_addr  write address
//   in_load_data  write data {op,imm}
//   in_run        1 = run program, 0 = stop after the current instruction
//   in_ready      downstream accepts the issued instruction
//   in_jump       take branch (sampled only in the handshake cycle)
//   in_jump_addr  branch target
//   out_valid     out_op/out_imm/out_pc carry a valid instruction
//   out_op        opcode field
//   out_imm       immediate field
//   out_pc        address of the issued instruction
//   out_halted    self-jump halt detected
// ---------------------------------------------------------------------------
module td4_fetch #(
  parameter int ADDR_W = 4,
  parameter int OP_W   = 4,
  parameter int IMM_W  = 4
) (
  input  logic                    in_clk,
  input  logic                    in_rst_n,
  input  logic                    in_load_en,
  input  logic [ADDR_W-1:0]       in_load_addr,
  input  logic [OP_W+IMM_W-1:0]   in_load_data,
  input  logic                    in_run,
  input  logic                    in_ready,
  input  logic                    in_jump,
  input  logic [ADDR_W-1:0]       in_jump_addr,
  output logic                    out_valid,
  output logic [OP_W-1:0]         out_op,
  output logic [IMM_W-1:0]        out_imm,
  output logic [ADDR_W-1:0]       out_pc,
  output logic                    out_halted
);

  localparam int INSTR_W = OP_W + IMM_W;
  localparam int DEPTH   = 2 ** ADDR_W;
  localparam int CMP_W   = (IMM_W > ADDR_W) ? IMM_W : ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t              r_state;
  state_t              w_next;

  logic [INSTR_W-1:0]  r_mem [0:DEPTH-1];
  logic [ADDR_W-1:0]   r_pc;
  logic [OP_W-1:0]     r_op;
  logic [IMM_W-1:0]    r_imm;
  logic [ADDR_W-1:0]   r_out_pc;

  logic                w_hs;
  logic                w_self_halt;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [CMP_W-1:0]    w_imm_cmp;
  logic [CMP_W-1:0]    w_pc_cmp;

  assign w_hs      = (r_state == S_ISSUE) && in_ready;
  assign w_pc_inc  = r_pc + ADDR_W'(1);
  assign w_imm_cmp = CMP_W'(r_imm);
  assign w_pc_cmp  = CMP_W'(r_out_pc);

  // Halt idiom: "JMP self" encoded as op=all-ones with imm equal to its own
  // address, and execute confirming the branch back to that same address.
  assign w_self_halt = (r_op == '1) && (w_imm_cmp == w_pc_cmp) &&
                       in_jump && (in_jump_addr == r_out_pc);

  // State register
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) r_state <= S_IDLE;
    else           r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_run) w_next = S_FETCH;
      S_FETCH: w_next = S_ISSUE;
      S_ISSUE: begin
        if (w_hs) begin
          if (w_self_halt) w_next = S_HALT;
          else if (in_run) w_next = S_FETCH;
          else             w_next = S_IDLE;
        end
      end
      S_HALT:  if (!in_run) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_valid  = (r_state == S_ISSUE);
    out_halted = (r_state == S_HALT);
  end

  // Datapath: issued fields only change in FETCH, so they hold across
  // stalls and keep the last issued values while idle.
  always_ff @(posedge in_clk) begin
    if (!in_rst_n) begin
      r_pc     <= '0;
      r_op     <= '0;
      r_imm    <= '0;
      r_out_pc <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          {r_op, r_imm} <= r_mem[r_pc];
          r_out_pc      <= r_pc;
        end
        S_ISSUE: if (w_hs) r_pc <= in_jump ? in_jump_addr : w_pc_inc;
        S_HALT:  if (!in_run) r_pc <= '0;
        default: ;
      endcase
    end
  end

  // Program memory: no reset of contents; a write coinciding with reset is dropped.
  always_ff @(posedge in_clk) begin
    if (in_rst_n && (r_state == S_IDLE) && in_load_en)
      r_mem[in_load_addr] <= in_load_data;
  end

  assign out_op  = r_op;
  assign out_imm = r_imm;
  assign out_pc  = r_out_pc;

endmodule

// File: tb/tb_td4_fetch.sv
// ---------------------------------------------------------------------------
// tb_td4_fetch : directed bench for td4_fetch with a transaction-level
// reference model (program memory copy, expected pc, latency countdown).
// ---------------------------------------------------------------------------
module tb_td4_fetch;

  logic       clk = 1'b0;
  logic       in_rst_n, in_load_en, in_run, in_ready, in_jump;
  logic [3:0] in_load_addr, in_jump_addr;
  logic [7:0] in_load_data;
  logic       out_valid, out_halted;
  logic [3:0] out_op, out_imm, out_pc;

  td4_fetch #(.ADDR_W(4), .OP_W(4), .IMM_W(4)) dut (
    .in_clk       (clk),
    .in_rst_n     (in_rst_n),
    .in_load_en   (in_load_en),
    .in_load_addr (in_load_addr),
    .in_load_data (in_load_data),
    .in_run       (in_run),
    .in_ready     (in_ready),
    .in_jump      (in_jump),
    .in_jump_addr (in_jump_addr),
    .out_valid    (out_valid),
    .out_op       (out_op),
    .out_imm      (out_imm),
    .out_pc       (out_pc),
    .out_halted   (out_halted)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] op;
    logic [31:0] imm;
    int          cyc;
  } iss_t;
  iss_t log_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_mem [16];
  logic [3:0] m_pc, m_lpc, m_lop, m_limm;
  logic       m_valid, m_halted, armed;
  int         m_due;

  initial begin
    logic [7:0] ins;
    logic       halt;
    armed = 1'b0;
    m_pc = '0; m_lpc = '0; m_lop = '0; m_limm = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_due = 0;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("valid", out_valid, m_valid);
        chk("halted", out_halted, m_halted);
        if (m_valid) begin
          ins = m_mem[m_pc];
          chk("pc", out_pc, m_pc);
          chk("op", out_op, ins[7:4]);
          chk("imm", out_imm, ins[3:0]);
        end else begin
          chk("hold_pc", out_pc, m_lpc);
          chk("hold_op", out_op, m_lop);
          chk("hold_imm", out_imm, m_limm);
        end
      end
      if (!in_rst_n) begin
        armed = 1'b1;
        m_pc = '0; m_lpc = '0; m_lop = '0; m_limm = '0;
        m_valid = 1'b0; m_halted = 1'b0; m_due = 0;
      end else if (armed) begin
        if (m_valid) begin
          if (in_ready) begin
            ins = m_mem[m_pc];
            log_q.push_back('{pc: out_pc, op: out_op, imm: out_imm, cyc: cyc});
            m_lpc = m_pc; m_lop = ins[7:4]; m_limm = ins[3:0];
            halt = (ins[7:4] == 4'hF) && (ins[3:0] == m_pc) && in_jump && (in_jump_addr == m_pc);
            m_pc = in_jump ? in_jump_addr : m_pc + 4'd1;
            m_valid = 1'b0;
            if (halt)        m_halted = 1'b1;
            else if (in_run) m_due = 2;
          end
        end else if (m_halted) begin
          if (!in_run) begin
            m_halted = 1'b0;
            m_pc = '0;
          end
        end else if (m_due == 0) begin
          if (in_load_en) m_mem[in_load_addr] = in_load_data;
          if (in_run) m_due = 2;
        end
        if (m_due > 0) begin
          m_due--;
          if (m_due == 0) m_valid = 1'b1;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic load(input logic [3:0] a, input logic [7:0] d);
    in_load_en = 1'b1; in_load_addr = a; in_load_data = d;
    tick(1);
    in_load_en = 1'b0;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      tick(1);
      n++;
    end
    if (out_valid !== 1'b1) chk("valid_timeout", out_valid, 1);
  endtask

  // Wait for an issue, stall 'stall' cycles (optionally with a spurious
  // jump request), then accept with the given jump.
  task automatic issue(input int stall, input logic spur, input logic jmp, input logic [3:0] ja);
    wait_valid();
    if (stall > 0) begin
      in_jump = spur; in_jump_addr = 4'd12;
      tick(stall);
    end
    in_ready = 1'b1; in_jump = jmp; in_jump_addr = ja;
    tick(1);
    in_ready = 1'b0; in_jump = 1'b0; in_jump_addr = '0;
  endtask

  task automatic chk_log(input int idx, input logic [31:0] pc, input logic [31:0] op, input logic [31:0] imm);
    if (idx >= log_q.size()) begin
      chk($sformatf("log%0d_missing", idx), log_q.size(), idx + 1);
    end else begin
      chk($sformatf("log%0d_pc", idx), log_q[idx].pc, pc);
      chk($sformatf("log%0d_op", idx), log_q[idx].op, op);
      chk($sformatf("log%0d_imm", idx), log_q[idx].imm, imm);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    logic [7:0] prog [16];
    int c0, n0;
    prog = '{8'h31, 8'h52, 8'h73, 8'h84, 8'hF4, 8'h95, 8'hA6, 8'hB7,
             8'hC8, 8'hD9, 8'hEA, 8'hFB, 8'h0C, 8'h1D, 8'h2E, 8'h00};
    in_rst_n = 1'b0; in_load_en = 1'b0; in_load_addr = '0; in_load_data = '0;
    in_run = 1'b0; in_ready = 1'b0; in_jump = 1'b0; in_jump_addr = '0;
    tick(3);
    in_rst_n = 1'b1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_halted", out_halted, 0);

    for (int i = 0; i < 16; i++) load(4'(i), prog[i]);

    // Sequential run, stall with spurious jump, jumps, wrap, halt
    c0 = cyc;
    in_run = 1'b1;
    issue(0, 1'b0, 1'b0, 4'd0);   // pc0
    issue(0, 1'b0, 1'b0, 4'd0);   // pc1
    issue(5, 1'b1, 1'b0, 4'd0);   // pc2, stalled, jump outside handshake
    issue(0, 1'b0, 1'b1, 4'd9);   // pc3 -> 9
    issue(0, 1'b0, 1'b1, 4'd15);  // pc9 -> 15
    issue(0, 1'b0, 1'b0, 4'd0);   // pc15 -> 0 (wrap)
    issue(0, 1'b0, 1'b1, 4'd4);   // pc0 -> 4
    issue(0, 1'b0, 1'b1, 4'd4);   // pc4 F4 self-jump -> halt
    tick(3);
    chk("halt_set", out_halted, 1);
    chk("halt_novalid", out_valid, 0);
    in_run = 1'b0;
    tick(2);
    chk("halt_clr", out_halted, 0);

    chk_log(0, 0, 3, 1);
    chk_log(1, 1, 5, 2);
    chk_log(2, 2, 7, 3);
    chk_log(3, 3, 8, 4);
    chk_log(4, 9, 4'hD, 9);
    chk_log(5, 15, 0, 0);
    chk_log(6, 0, 3, 1);
    chk_log(7, 4, 4'hF, 4);
    if (log_q.size() >= 3) begin
      chk("lat_first", log_q[0].cyc - c0, 2);
      chk("lat_b2b", log_q[1].cyc - log_q[0].cyc, 2);
      chk("lat_stall", log_q[2].cyc - log_q[1].cyc, 7);
    end

    // Single step from pc0 with an ignored write during ISSUE
    n0 = log_q.size();
    in_run = 1'b1;
    tick(1);
    in_run = 1'b0;
    wait_valid();
    in_load_en = 1'b1; in_load_addr = 4'd0; in_load_data = 8'hEE;
    tick(1);
    in_load_en = 1'b0;
    issue(0, 1'b0, 1'b0, 4'd0);
    tick(6);
    chk("step_count", log_q.size(), n0 + 1);
    chk_log(n0, 0, 3, 1);

    // Load and run in the same idle cycle at pc1
    in_load_en = 1'b1; in_load_addr = 4'd1; in_load_data = 8'h66; in_run = 1'b1;
    tick(1);
    in_load_en = 1'b0; in_run = 1'b0;
    issue(0, 1'b0, 1'b0, 4'd0);
    tick(4);
    chk_log(n0 + 1, 1, 6, 6);

    // Reset mid-issue, then reset against a write, then rerun from 0
    in_run = 1'b1;
    wait_valid();
    in_rst_n = 1'b0; in_run = 1'b0;
    tick(1);
    in_rst_n = 1'b1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pc", out_pc, 0);
    chk("midrst_op", out_op, 0);
    in_rst_n = 1'b0; in_load_en = 1'b1; in_load_addr = 4'd0; in_load_data = 8'h99;
    tick(1);
    in_rst_n = 1'b1; in_load_en = 1'b0;
    n0 = log_q.size();
    in_run = 1'b1;
    tick(1);
    in_run = 1'b0;
    issue(0, 1'b0, 1'b0, 4'd0);
    tick(4);
    chk_log(n0, 0, 3, 1);

    tick(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
